// File: rtl/l2cache_control.sv
// Sequencing controller for the 4-way, 8-set L2 cache datapath: tag check,
// LRU update, write-hit merge, dirty victim writeback, line allocate and replay.
module l2cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 l2_mem_read,
  input  logic                 l2_mem_write,
  input  logic                 hit,
  input  logic [3:0]           way_hit,
  input  logic [1:0]           pseudolru_out,
  input  logic                 dirtymux_out,
  input  logic                 pmem_resp,
  output logic                 l2_mem_resp,
  output logic [3:0]           data_write,
  output logic [3:0]           tag_write,
  output logic [3:0]           valid_write,
  output logic [3:0]           dirty_write,
  output logic [3:0]           dirty_in,
  output logic                 pseudolru_write,
  output logic                 rwmux_sel,
  output logic                 pmemmux_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  // state     | meaning
  // IDLE      | waiting for an L1-side request
  // CHECK     | tag lookup; completes on hit, picks victim on miss
  // WRITEBACK | dirty victim line written to pmem
  // ALLOCATE  | line fetched from pmem and filled into victim way
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t     state, state_nxt;
  logic [1:0] victim, victim_nxt;
  logic       replay, replay_nxt;
  logic       hit_inc, miss_inc;
  logic       req, is_write;
  logic [3:0] victim_onehot;

  assign req           = l2_mem_read | l2_mem_write;
  // Simultaneous read and write is serviced as a write.
  assign is_write      = l2_mem_write;
  assign victim_onehot = 4'b0001 << victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= 2'd0;
      replay <= 1'b0;
    end else begin
      state  <= state_nxt;
      victim <= victim_nxt;
      replay <= replay_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != CNT_MAX))
        hit_count <= hit_count + 1'b1;
      if (miss_inc && (miss_count != CNT_MAX))
        miss_count <= miss_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    victim_nxt      = victim;
    replay_nxt      = replay;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    l2_mem_resp     = 1'b0;
    data_write      = 4'b0000;
    tag_write       = 4'b0000;
    valid_write     = 4'b0000;
    dirty_write     = 4'b0000;
    dirty_in        = 4'b0000;
    pseudolru_write = 1'b0;
    rwmux_sel       = 1'b0;
    pmemmux_sel     = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = CHECK;
          replay_nxt = 1'b0;
        end
      end

      CHECK: begin
        if (!req) begin
          // Requester abandoned the access; quietly go back to idle.
          state_nxt = IDLE;
        end else if (hit) begin
          l2_mem_resp     = 1'b1;
          pseudolru_write = 1'b1;
          if (is_write) begin
            data_write  = way_hit;
            dirty_write = way_hit;
            dirty_in    = way_hit;
            rwmux_sel   = 1'b1;
          end
          hit_inc   = ~replay;
          state_nxt = IDLE;
        end else begin
          victim_nxt = pseudolru_out;
          miss_inc   = 1'b1;
          state_nxt  = dirtymux_out ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmemmux_sel = 1'b1;
        pmem_write  = 1'b1;
        if (pmem_resp)
          state_nxt = ALLOCATE;
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_write  = victim_onehot;
          tag_write   = victim_onehot;
          valid_write = victim_onehot;
          dirty_write = victim_onehot;
          state_nxt   = CHECK;
          replay_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2cache_control.sv
// Directed table-driven bench for l2cache_control, plus hand sequences for
// async reset mid-allocate and counter saturation.
module tb_l2cache_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l2_mem_read, l2_mem_write, hit, dirtymux_out, pmem_resp;
  logic [3:0]    way_hit;
  logic [1:0]    pseudolru_out;
  logic          l2_mem_resp, pseudolru_write, rwmux_sel, pmemmux_sel;
  logic          pmem_read, pmem_write;
  logic [3:0]    data_write, tag_write, valid_write, dirty_write, dirty_in;
  logic [CW-1:0] hit_count, miss_count;

  int n_vec = 0;
  int n_bad = 0;

  l2cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .hit(hit), .way_hit(way_hit), .pseudolru_out(pseudolru_out),
    .dirtymux_out(dirtymux_out), .pmem_resp(pmem_resp),
    .l2_mem_resp(l2_mem_resp), .data_write(data_write), .tag_write(tag_write),
    .valid_write(valid_write), .dirty_write(dirty_write), .dirty_in(dirty_in),
    .pseudolru_write(pseudolru_write), .rwmux_sel(rwmux_sel),
    .pmemmux_sel(pmemmux_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // {resp, data_w, tag_w, valid_w, dirty_w, dirty_in, lru_w, rwmux, pmemmux, pread, pwrite}
  typedef struct packed {
    logic          rd, wr, h;
    logic [3:0]    wh;
    logic [1:0]    lru;
    logic          dm, pr;
    logic [25:0]   exp;
    logic [CW-1:0] eh, em;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [25:0] e(input logic r, input logic [3:0] dw, tw, vw, dyw, din,
                                    input logic plw, rw, pm, prd, pwr);
    return {r, dw, tw, vw, dyw, din, plw, rw, pm, prd, pwr};
  endfunction

  function automatic vec_t mk(input logic rd, wr, h, input logic [3:0] wh, input logic [1:0] lru,
                              input logic dm, pr, input logic [25:0] exp,
                              input logic [CW-1:0] eh, em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.h = h; v.wh = wh; v.lru = lru; v.dm = dm; v.pr = pr;
    v.exp = exp; v.eh = eh; v.em = em;
    return v;
  endfunction

  function automatic logic [25:0] observed();
    return {l2_mem_resp, data_write, tag_write, valid_write, dirty_write, dirty_in,
            pseudolru_write, rwmux_sel, pmemmux_sel, pmem_read, pmem_write};
  endfunction

  task automatic check(input string name, input logic [25:0] got_o, exp_o,
                       input logic [CW-1:0] exp_h, exp_m);
    n_vec++;
    if (got_o !== exp_o || hit_count !== exp_h || miss_count !== exp_m) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want %h, hit_count got %0d want %0d, miss_count got %0d want %0d",
               name, got_o, exp_o, hit_count, exp_h, miss_count, exp_m);
    end
  endtask

  // Drive just after a rising edge, compare on the falling edge, then advance.
  task automatic apply(input vec_t v, input string name);
    l2_mem_read = v.rd; l2_mem_write = v.wr; hit = v.h; way_hit = v.wh;
    pseudolru_out = v.lru; dirtymux_out = v.dm; pmem_resp = v.pr;
    @(negedge clk);
    check(name, observed(), v.exp, v.eh, v.em);
    @(posedge clk); #1;
  endtask

  logic [25:0] E0, AL, WB, HITR;
  function automatic logic [25:0] fill(input logic [3:0] w);
    return e(0, w, w, w, w, 4'b0000, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [25:0] hitw(input logic [3:0] w);
    return e(1, w, 4'b0000, 4'b0000, w, w, 1, 1, 0, 0, 0);
  endfunction

  initial begin
    int h;
    E0   = '0;
    AL   = e(0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1, 0);
    WB   = e(0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 0, 1);
    HITR = e(1, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1, 0, 0, 0, 0);

    // rd wr h  wh     lru dm pr  expected     hit miss
    // cold read miss, victim 2, pmem_resp on 5th allocate cycle
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, E0,          0,0));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, E0,          0,0));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, AL,          0,1));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, AL,          0,1));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, AL,          0,1));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,0, AL,          0,1));
    vecs.push_back(mk(1,0,0,4'b0000,2,0,1, fill(4'b0100),0,1));
    vecs.push_back(mk(1,0,1,4'b0100,2,0,0, HITR,        0,1));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0, E0,          0,1));
    // write hit on way 1
    vecs.push_back(mk(0,1,1,4'b0010,0,0,0, E0,          0,1));
    vecs.push_back(mk(0,1,1,4'b0010,0,0,0, hitw(4'b0010),0,1));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0, E0,          1,1));
    // dirty write miss, victim 3 latched, lru input moves to 1 during writeback
    vecs.push_back(mk(0,1,0,4'b0000,3,1,0, E0,          1,1));
    vecs.push_back(mk(0,1,0,4'b0000,3,1,0, E0,          1,1));
    vecs.push_back(mk(0,1,0,4'b0000,1,1,0, WB,          1,2));
    vecs.push_back(mk(0,1,0,4'b0000,1,1,0, WB,          1,2));
    vecs.push_back(mk(0,1,0,4'b0000,1,1,1, WB,          1,2));
    vecs.push_back(mk(0,1,0,4'b0000,1,0,0, AL,          1,2));
    vecs.push_back(mk(0,1,0,4'b0000,1,0,1, fill(4'b1000),1,2));
    vecs.push_back(mk(0,1,1,4'b1000,1,0,0, hitw(4'b1000),1,2));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0, E0,          1,2));
    // read+write together behaves as write; then back-to-back read hit
    vecs.push_back(mk(1,1,1,4'b0001,0,0,0, E0,          1,2));
    vecs.push_back(mk(1,1,1,4'b0001,0,0,0, hitw(4'b0001),1,2));
    vecs.push_back(mk(1,0,1,4'b0100,0,0,0, E0,          2,2));
    vecs.push_back(mk(1,0,1,4'b0100,0,0,0, HITR,        2,2));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0, E0,          3,2));
    // write miss dropped during writeback: wb and fill finish, no resp
    vecs.push_back(mk(0,1,0,4'b0000,0,1,0, E0,          3,2));
    vecs.push_back(mk(0,1,0,4'b0000,0,1,0, E0,          3,2));
    vecs.push_back(mk(0,0,0,4'b0000,0,1,0, WB,          3,3));
    vecs.push_back(mk(0,0,0,4'b0000,0,1,1, WB,          3,3));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,1, fill(4'b0001),3,3));
    vecs.push_back(mk(0,0,1,4'b0001,0,0,0, E0,          3,3));
    vecs.push_back(mk(0,0,1,4'b0001,0,0,0, E0,          3,3));
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0, E0,          3,3));

    rst_n = 1'b0;
    l2_mem_read = 1'b1; l2_mem_write = 1'b0; hit = 1'b1; way_hit = 4'b0001;
    pseudolru_out = 2'd0; dirtymux_out = 1'b0; pmem_resp = 1'b1;
    #12;
    check("reset_hold", observed(), E0, 0, 0);
    l2_mem_read = 1'b0; hit = 1'b0; way_hit = 4'b0000; pmem_resp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // async reset while allocating a line into way 1
    apply(mk(0,1,0,4'b0000,1,0,0, E0, 3,3), "rst_seq_idle");
    apply(mk(0,1,0,4'b0000,1,0,0, E0, 3,3), "rst_seq_check");
    apply(mk(0,1,0,4'b0000,1,0,0, AL, 3,4), "rst_seq_alloc");
    pmem_resp = 1'b1;
    #1 check("rst_seq_fill", observed(), fill(4'b0010), 3, 4);
    rst_n = 1'b0;
    #1 check("rst_async", observed(), E0, 0, 0);
    l2_mem_write = 1'b0; pmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(0,0,0,4'b0000,0,0,0, E0,   0,0), "rst_after_idle");
    apply(mk(1,0,1,4'b0001,0,0,0, E0,   0,0), "rst_after_req");
    apply(mk(1,0,1,4'b0001,0,0,0, HITR, 0,0), "rst_after_hit");

    // counter saturation: 17 first-lookup hits in total, count sticks at 15
    h = 1;
    for (int i = 0; i < 16; i++) begin
      apply(mk(1,0,1,4'b0001,0,0,0, E0,   CW'((h > 15) ? 15 : h), 0), $sformatf("sat_idle%0d", i));
      apply(mk(1,0,1,4'b0001,0,0,0, HITR, CW'((h > 15) ? 15 : h), 0), $sformatf("sat_hit%0d", i));
      h++;
    end
    apply(mk(0,0,0,4'b0000,0,0,0, E0,   15,0), "sat_17");
    apply(mk(1,0,1,4'b0001,0,0,0, E0,   15,0), "sat_more_idle");
    apply(mk(1,0,1,4'b0001,0,0,0, HITR, 15,0), "sat_more_hit");
    apply(mk(0,0,0,4'b0000,0,0,0, E0,   15,0), "sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
